// File: rtl/gpio_bridge_pkg.sv
// Shared constants and types for the Wishbone GPIO/IRQ bridge.
package gpio_bridge_pkg;

  localparam int WB_DW     = 32;
  localparam int MAX_WORDS = 4;

  localparam logic [7:0] GROUP_STRIDE = 8'h10;

  localparam logic [7:0] OFS_OUT     = 8'h00;
  localparam logic [7:0] OFS_OEB     = 8'h10;
  localparam logic [7:0] OFS_IN      = 8'h20;
  localparam logic [7:0] OFS_RISE_EN = 8'h30;
  localparam logic [7:0] OFS_FALL_EN = 8'h40;
  localparam logic [7:0] OFS_PEND    = 8'h50;

  typedef enum logic {
    ST_IDLE,
    ST_ACK
  } wb_state_e;

  function automatic logic [7:0] group_base(
    input logic [7:0] ofs
  );
    return ofs & ~(GROUP_STRIDE - 8'h01);
  endfunction

endpackage

// File: rtl/wb_gpio_irq_bridge_sync.sv
// Input synchroniser with a trailing history flop and
// enable-qualified rise/fall detection.
module gpio_sync_edge #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] rise_en,
  input  logic [WIDTH-1:0] fall_en,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [DEPTH-1:0][WIDTH-1:0] stg_q;
  logic [WIDTH-1:0]            prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_q  <= '0;
      prev_q <= '0;
    end else begin
      stg_q  <= {stg_q[DEPTH-2:0], d};
      prev_q <= stg_q[DEPTH-1];
    end
  end

  assign sync = stg_q[DEPTH-1];
  assign rise = sync & ~prev_q & rise_en;
  assign fall = ~sync & prev_q & fall_en;

endmodule

// File: rtl/wb_gpio_irq_bridge.sv
// Wishbone slave GPIO block: registered pads, synced inputs,
// sticky edge interrupts folded onto NUM_IRQ lines.
module wb_gpio_irq_bridge
  import gpio_bridge_pkg::*;
#(
  parameter int          NUM_GPIO    = 38,
  parameter int          NUM_IRQ     = 3,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                wbs_stb_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_we_i,
  input  logic [3:0]          wbs_sel_i,
  input  logic [31:0]         wbs_dat_i,
  input  logic [31:0]         wbs_adr_i,
  output logic                wbs_ack_o,
  output logic [31:0]         wbs_dat_o,
  input  logic [NUM_GPIO-1:0] gpio_i,
  output logic [NUM_GPIO-1:0] gpio_o,
  output logic [NUM_GPIO-1:0] gpio_oeb_no,
  output logic [NUM_IRQ-1:0]  irq_o
);

  wb_state_e state_q, state_d;

  logic [NUM_GPIO-1:0] out_q, oeb_q;
  logic [NUM_GPIO-1:0] rise_en_q, fall_en_q, pend_q;
  logic [NUM_GPIO-1:0] in_sync, rise, fall;
  logic [NUM_GPIO-1:0] wr_mask, wr_data, clr, rd_vec;
  logic [WB_DW-1:0]    rd_word, dat_q;
  logic [NUM_IRQ-1:0]  irq_q, irq_d;
  logic [7:0]          grp;
  logic [1:0]          word;
  logic                hit, accept, wr;
  logic                unused_adr;

  gpio_sync_edge #(
    .WIDTH (NUM_GPIO),
    .DEPTH (SYNC_STAGES)
  ) u_sync (
    .clk     (clk_i),
    .rst_n   (rst_ni),
    .d       (gpio_i),
    .rise_en (rise_en_q),
    .fall_en (fall_en_q),
    .sync    (in_sync),
    .rise    (rise),
    .fall    (fall)
  );

  assign hit    = wbs_adr_i[31:8] == BASE_ADDR[31:8];
  assign grp    = group_base(wbs_adr_i[7:0]);
  assign word   = wbs_adr_i[3:2];
  assign accept = wbs_cyc_i & wbs_stb_i & hit
                & (state_q == ST_IDLE);
  assign wr     = accept & wbs_we_i;

  assign unused_adr = ^wbs_adr_i[1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_ACK;
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign wbs_ack_o = (state_q == ST_ACK);

  // Pin i lives in word i/32, bit i%32 of that word.
  for (genvar i = 0; i < NUM_GPIO; i++) begin : g_pin
    localparam int W = i / WB_DW;
    localparam int B = i % WB_DW;
    assign wr_mask[i] = (word == W[1:0]) & wbs_sel_i[B/8];
    assign wr_data[i] = wbs_dat_i[B];
  end

  always_comb begin
    rd_vec = '0;
    unique case (1'b1)
      grp == OFS_OUT:     rd_vec = out_q;
      grp == OFS_OEB:     rd_vec = oeb_q;
      grp == OFS_IN:      rd_vec = in_sync;
      grp == OFS_RISE_EN: rd_vec = rise_en_q;
      grp == OFS_FALL_EN: rd_vec = fall_en_q;
      grp == OFS_PEND:    rd_vec = pend_q;
      default:            rd_vec = '0;
    endcase
  end

  for (genvar b = 0; b < WB_DW; b++) begin : g_rd
    logic [MAX_WORDS-1:0] col;
    for (genvar w = 0; w < MAX_WORDS; w++) begin : g_w
      if (w * WB_DW + b < NUM_GPIO) begin : g_v
        assign col[w] = rd_vec[w*WB_DW+b];
      end else begin : g_z
        assign col[w] = 1'b0;
      end
    end
    assign rd_word[b] = col[word];
  end

  for (genvar k = 0; k < NUM_IRQ; k++) begin : g_irq
    logic [NUM_GPIO-1:0] member;
    for (genvar i = 0; i < NUM_GPIO; i++) begin : g_m
      assign member[i] = (i % NUM_IRQ == k);
    end
    assign irq_d[k] = |(pend_q & member);
  end

  assign clr = (wr && grp == OFS_PEND)
             ? (wr_data & wr_mask) : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q     <= '0;
      oeb_q     <= '1;
      rise_en_q <= '0;
      fall_en_q <= '0;
      pend_q    <= '0;
      dat_q     <= '0;
      irq_q     <= '0;
    end else begin
      if (wr && grp == OFS_OUT)
        out_q <= (out_q & ~wr_mask) | (wr_data & wr_mask);
      if (wr && grp == OFS_OEB)
        oeb_q <= (oeb_q & ~wr_mask) | (wr_data & wr_mask);
      if (wr && grp == OFS_RISE_EN)
        rise_en_q <= (rise_en_q & ~wr_mask)
                   | (wr_data & wr_mask);
      if (wr && grp == OFS_FALL_EN)
        fall_en_q <= (fall_en_q & ~wr_mask)
                   | (wr_data & wr_mask);
      // A fresh edge wins over a same-cycle clear.
      pend_q <= (pend_q & ~clr) | rise | fall;
      dat_q  <= (accept && !wbs_we_i) ? rd_word : '0;
      irq_q  <= irq_d;
    end
  end

  assign wbs_dat_o   = dat_q;
  assign gpio_o      = out_q;
  assign gpio_oeb_no = oeb_q;
  assign irq_o       = irq_q;

endmodule

// File: tb/tb_wb_gpio_irq_bridge.sv
// Bench for wb_gpio_irq_bridge: directed spec cases plus
// random traffic against a register-level reference model.
module tb_wb_gpio_irq_bridge;

  localparam int          NG   = 38;
  localparam int          NI   = 3;
  localparam int          SS   = 2;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          cyc, stb, we;
  logic [3:0]    sel;
  logic [31:0]   dat, adr, rdat;
  logic          ack;
  logic [NG-1:0] gpio_i, gpio_o, oeb;
  logic [NI-1:0] irq;

  int n_cmp = 0;
  int n_bad = 0;

  logic [NG-1:0] m_out, m_oeb, m_rise, m_fall, m_pend;
  logic [NG-1:0] h [0:SS];
  logic          m_busy, m_ack;
  logic [31:0]   m_dat;
  logic [NI-1:0] m_irq;

  always #5 clk = ~clk;

  wb_gpio_irq_bridge #(
    .NUM_GPIO    (NG),
    .NUM_IRQ     (NI),
    .SYNC_STAGES (SS),
    .BASE_ADDR   (BASE)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .wbs_stb_i   (stb),
    .wbs_cyc_i   (cyc),
    .wbs_we_i    (we),
    .wbs_sel_i   (sel),
    .wbs_dat_i   (dat),
    .wbs_adr_i   (adr),
    .wbs_ack_o   (ack),
    .wbs_dat_o   (rdat),
    .gpio_i      (gpio_i),
    .gpio_o      (gpio_o),
    .gpio_oeb_no (oeb),
    .irq_o       (irq)
  );

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [NI-1:0] fold(
    input logic [NG-1:0] p
  );
    logic [NI-1:0] f;
    f = '0;
    for (int i = 0; i < NG; i++)
      if (p[i]) f[i % NI] = 1'b1;
    return f;
  endfunction

  task automatic model_reset();
    m_out  = '0;
    m_oeb  = '1;
    m_rise = '0;
    m_fall = '0;
    m_pend = '0;
    m_busy = 1'b0;
    m_ack  = 1'b0;
    m_dat  = '0;
    m_irq  = '0;
    for (int j = 0; j <= SS; j++) h[j] = '0;
  endtask

  // Advance model and DUT by one clock, then compare outputs.
  task automatic step();
    logic [NG-1:0]  sync_b, prev_b, set, clr, wv;
    logic [127:0]   r128, m128, d128;
    logic [31:0]    rd;
    logic           acc;
    int             w;
    sync_b = h[SS-1];
    prev_b = h[SS];
    set = (sync_b & ~prev_b & m_rise)
        | (~sync_b & prev_b & m_fall);
    acc = cyc && stb && !m_busy
        && (adr[31:8] == BASE[31:8]);
    w   = int'(adr[3:2]);
    rd  = '0;
    clr = '0;
    if (acc) begin
      case (adr[7:4])
        4'h0:    r128 = 128'(m_out);
        4'h1:    r128 = 128'(m_oeb);
        4'h2:    r128 = 128'(sync_b);
        4'h3:    r128 = 128'(m_rise);
        4'h4:    r128 = 128'(m_fall);
        4'h5:    r128 = 128'(m_pend);
        default: r128 = '0;
      endcase
      r128 = r128 >> (32 * w);
      rd   = r128[31:0];
      if (we) begin
        m128 = '0;
        for (int b = 0; b < 4; b++)
          if (sel[b]) m128[8*b +: 8] = 8'hFF;
        m128 = m128 << (32 * w);
        d128 = 128'(dat) << (32 * w);
        wv   = d128[NG-1:0] & m128[NG-1:0];
        case (adr[7:4])
          4'h0: m_out  = (m_out  & ~m128[NG-1:0]) | wv;
          4'h1: m_oeb  = (m_oeb  & ~m128[NG-1:0]) | wv;
          4'h3: m_rise = (m_rise & ~m128[NG-1:0]) | wv;
          4'h4: m_fall = (m_fall & ~m128[NG-1:0]) | wv;
          4'h5: clr    = wv;
          default: ;
        endcase
      end
    end
    m_irq  = fold(m_pend);
    m_pend = (m_pend & ~clr) | set;
    m_ack  = acc;
    m_dat  = (acc && !we) ? rd : 32'h0;
    m_busy = acc;
    for (int j = SS; j > 0; j--) h[j] = h[j-1];
    h[0] = gpio_i;
    @(posedge clk);
    #1;
    check("ack",    64'(ack),    64'(m_ack));
    check("rdata",  64'(rdat),   64'(m_dat));
    check("gpio_o", 64'(gpio_o), 64'(m_out));
    check("oeb",    64'(oeb),    64'(m_oeb));
    check("irq",    64'(irq),    64'(m_irq));
  endtask

  task automatic wb(input  logic [31:0] a,
                    input  logic        w,
                    input  logic [3:0]  s,
                    input  logic [31:0] d,
                    output logic [31:0] r);
    adr = a; we = w; sel = s; dat = d;
    cyc = 1'b1; stb = 1'b1;
    step();
    check("ack_hi", 64'(ack), 64'd1);
    r = rdat;
    cyc = 1'b0; stb = 1'b0;
    step();
    check("ack_lo", 64'(ack), 64'd0);
  endtask

  initial begin
    logic [31:0] r;
    rst_ni = 1'b0;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    sel = '0; dat = '0; adr = '0;
    gpio_i = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack",  64'(ack),    64'd0);
    check("rst_dat",  64'(rdat),   64'd0);
    check("rst_out",  64'(gpio_o), 64'd0);
    check("rst_oeb",  64'(oeb),    64'h3F_FFFF_FFFF);
    check("rst_irq",  64'(irq),    64'd0);
    rst_ni = 1'b1;

    wb(BASE + 32'h10, 1'b0, 4'hF, 32'h0, r);
    check("oeb_w0", 64'(r), 64'hFFFF_FFFF);
    wb(BASE + 32'h14, 1'b0, 4'hF, 32'h0, r);
    check("oeb_w1", 64'(r), 64'h3F);
    wb(BASE + 32'h00, 1'b0, 4'hF, 32'h0, r);
    check("out_w0", 64'(r), 64'h0);

    wb(BASE + 32'h00, 1'b1, 4'b0001, 32'hA5A5_A5A5, r);
    check("out_byte", 64'(gpio_o), 64'hA5);
    wb(BASE + 32'h04, 1'b1, 4'hF, 32'hFFFF_FFFF, r);
    check("out_hi", 64'(gpio_o), 64'h3F_0000_00A5);
    wb(BASE + 32'h04, 1'b0, 4'hF, 32'h0, r);
    check("out_w1_rd", 64'(r), 64'h3F);

    wb(BASE + 32'h30, 1'b1, 4'hF, 32'h20, r);
    gpio_i[5] = 1'b1;
    step();
    step();
    wb(BASE + 32'h20, 1'b0, 4'hF, 32'h0, r);
    check("in5_2clk", 64'(r), 64'h20);
    check("irq2_set", 64'(irq[2]), 64'd1);
    wb(BASE + 32'h50, 1'b0, 4'hF, 32'h0, r);
    check("pend5", 64'(r), 64'h20);

    gpio_i[33] = 1'b1;
    repeat (3) step();
    wb(BASE + 32'h44, 1'b1, 4'b0001, 32'h2, r);
    gpio_i[33] = 1'b0;
    repeat (3) step();
    check("irq0_early", 64'(irq[0]), 64'd0);
    step();
    check("irq0_set", 64'(irq[0]), 64'd1);
    wb(BASE + 32'h54, 1'b0, 4'hF, 32'h0, r);
    check("pend33", 64'(r), 64'h2);
    wb(BASE + 32'h54, 1'b1, 4'b0001, 32'h2, r);
    check("irq0_clr", 64'(irq[0]), 64'd0);

    wb(BASE + 32'h30, 1'b1, 4'hF, 32'h0, r);
    wb(BASE + 32'h50, 1'b0, 4'hF, 32'h0, r);
    check("pend_kept", 64'(r), 64'h20);
    wb(BASE + 32'h50, 1'b1, 4'b1110, 32'h20, r);
    wb(BASE + 32'h50, 1'b0, 4'hF, 32'h0, r);
    check("w1c_sel", 64'(r), 64'h20);

    wb(BASE + 32'h30, 1'b1, 4'hF, 32'h20, r);
    gpio_i[5] = 1'b0;
    repeat (3) step();
    gpio_i[5] = 1'b1;
    step();
    step();
    wb(BASE + 32'h50, 1'b1, 4'b0001, 32'h20, r);
    wb(BASE + 32'h50, 1'b0, 4'hF, 32'h0, r);
    check("w1c_race", 64'(r), 64'h20);
    wb(BASE + 32'h50, 1'b1, 4'b0001, 32'h20, r);
    wb(BASE + 32'h50, 1'b0, 4'hF, 32'h0, r);
    check("w1c_clr", 64'(r), 64'h0);

    adr = BASE + 32'h100; we = 1'b0; sel = 4'hF;
    cyc = 1'b1; stb = 1'b1;
    repeat (8) begin
      step();
      check("oow_noack", 64'(ack), 64'd0);
    end
    cyc = 1'b0; stb = 1'b0;
    step();
    wb(BASE + 32'h80, 1'b0, 4'hF, 32'h0, r);
    check("unmapped", 64'(r), 64'h0);

    wb(BASE + 32'h30, 1'b1, 4'hF, 32'hFFFF_FFFF, r);
    wb(BASE + 32'h34, 1'b1, 4'hF, 32'hFFFF_FFFF, r);
    wb(BASE + 32'h40, 1'b1, 4'hF, 32'hFFFF_FFFF, r);
    wb(BASE + 32'h44, 1'b1, 4'hF, 32'hFFFF_FFFF, r);
    repeat (400) begin
      gpio_i = gpio_i
             ^ (NG'({$urandom, $urandom})
             &  NG'({$urandom, $urandom})
             &  NG'({$urandom, $urandom}));
      cyc = 1'($urandom);
      stb = 1'($urandom);
      we  = 1'($urandom);
      sel = 4'($urandom);
      dat = $urandom;
      if ($urandom_range(0, 9) == 0) adr = $urandom;
      else adr = {BASE[31:8], 8'($urandom)};
      step();
    end
    cyc = 1'b0; stb = 1'b0;
    step();

    wb(BASE + 32'h00, 1'b1, 4'hF, 32'h1234_5678, r);
    wb(BASE + 32'h10, 1'b1, 4'hF, 32'h0, r);
    adr = BASE; we = 1'b1; sel = 4'hF;
    dat = 32'hFFFF_FFFF;
    cyc = 1'b1; stb = 1'b1;
    step();
    check("mid_ack", 64'(ack), 64'd1);
    rst_ni = 1'b0;
    #1;
    check("arst_ack", 64'(ack),    64'd0);
    check("arst_dat", 64'(rdat),   64'd0);
    check("arst_out", 64'(gpio_o), 64'd0);
    check("arst_oeb", 64'(oeb),    64'h3F_FFFF_FFFF);
    cyc = 1'b0; stb = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    step();
    check("post_rst_ack", 64'(ack), 64'd0);
    wb(BASE + 32'h00, 1'b0, 4'hF, 32'h0, r);
    check("post_rst_out", 64'(r), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
